// File: rtl/y86_pkg.sv
// Shared Y86-64 constants, memory-stage FSM states and the W-register control payload.
package y86_pkg;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;

    localparam logic [3:0] RNONE    = 4'hF;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] stat;
        logic [3:0] icode;
        logic [3:0] dste;
        logic [3:0] dstm;
    } w_ctl_t;

    function automatic logic is_wr_op(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
    endfunction

    function automatic logic is_rd_op(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
    endfunction

    // popq/ret address the stack through valA; everything else through valE
    function automatic logic uses_vala_addr(input logic [3:0] icode);
        return (icode == I_POPQ) || (icode == I_RET);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port data RAM: synchronous write, registered read with hold and clear.
module dmem_ram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_clr,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array is deliberately not reset; the owner initialises it by sweeping.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register doubles as the loaded-data field of the W register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage_pipe.sv
// Y86-64 memory stage: data memory access for the M instruction, W register,
// post-reset init sweep and sticky halt on a non-AOK status.
module mem_stage_pipe
    import y86_pkg::*;
#(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       DEPTH    = 1024,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_m_stall,
    input  logic              i_m_bubble,
    input  logic [3:0]        i_m_stat,
    input  logic [3:0]        i_m_icode,
    input  logic [DATA_W-1:0] i_m_vala,
    input  logic [DATA_W-1:0] i_m_vale,
    input  logic [DATA_W-1:0] i_m_valp,
    input  logic [3:0]        i_m_dste,
    input  logic [3:0]        i_m_dstm,
    output logic [3:0]        o_w_stat,
    output logic [3:0]        o_w_icode,
    output logic [DATA_W-1:0] o_w_vale,
    output logic [DATA_W-1:0] o_w_valm,
    output logic [3:0]        o_w_dste,
    output logic [3:0]        o_w_dstm,
    output logic              o_busy,
    output logic              o_dmem_error
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            r_state;
    state_e            w_state_nx;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  w_cnt_nx;
    w_ctl_t            r_ctl;
    w_ctl_t            w_ctl_nx;
    logic [DATA_W-1:0] r_vale;
    logic [DATA_W-1:0] w_vale_nx;
    logic              r_err;
    logic              w_err_nx;
    logic              r_busy;

    logic              w_is_rd;
    logic              w_is_wr;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_wdata;
    logic              w_adr_err;

    logic              w_ram_we;
    logic              w_ram_re;
    logic              w_ram_clr;
    logic [IDX_W-1:0]  w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_rdata;

    // Address decode and bounds/alignment check for the M instruction.
    assign w_is_rd   = is_rd_op(i_m_icode);
    assign w_is_wr   = is_wr_op(i_m_icode);
    assign w_addr    = uses_vala_addr(i_m_icode) ? i_m_vala : i_m_vale;
    assign w_wdata   = (i_m_icode == I_CALL) ? i_m_valp : i_m_vala;
    assign w_word    = w_addr >> OFF_W;
    assign w_adr_err = ((w_addr & DATA_W'(BYTES - 1)) != '0) || (w_word >= DATA_W'(DEPTH));

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_ctl_nx    = r_ctl;
        w_vale_nx   = r_vale;
        w_err_nx    = r_err;
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_clr   = 1'b0;
        w_ram_addr  = w_word[IDX_W-1:0];
        w_ram_wdata = w_wdata;

        case (r_state)
            ST_INIT: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_cnt;
                w_ram_wdata = INIT_VAL;
                w_cnt_nx    = r_cnt + IDX_W'(1);
                if (r_cnt == IDX_W'(DEPTH - 1)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_m_stall) begin
                    w_ram_clr = 1'b1;
                    w_err_nx  = 1'b0;
                    if (i_m_bubble) begin
                        w_ctl_nx  = '{stat: STAT_AOK, icode: I_NOP, dste: RNONE, dstm: RNONE};
                        w_vale_nx = '0;
                    end else begin
                        w_ctl_nx  = '{stat: i_m_stat, icode: i_m_icode,
                                      dste: i_m_dste, dstm: i_m_dstm};
                        w_vale_nx = i_m_vale;
                        if ((i_m_stat == STAT_AOK) && (w_is_rd || w_is_wr)) begin
                            if (w_adr_err) begin
                                w_ctl_nx.stat = STAT_ADR;
                                w_err_nx      = 1'b1;
                            end else begin
                                w_ram_we  = w_is_wr;
                                w_ram_re  = w_is_rd;
                                w_ram_clr = !w_is_rd;
                            end
                        end
                        if (w_ctl_nx.stat != STAT_AOK) begin
                            w_state_nx = ST_HALT;
                        end
                    end
                end
            end
            default: begin
                // Halted: W frozen and memory untouched until reset.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_ctl   <= '{stat: STAT_AOK, icode: I_NOP, dste: RNONE, dstm: RNONE};
            r_vale  <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_ctl   <= w_ctl_nx;
            r_vale  <= w_vale_nx;
            r_err   <= w_err_nx;
            r_busy  <= (w_state_nx == ST_INIT);
        end
    end

    dmem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_clr   (w_ram_clr),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_rdata)
    );

    assign o_w_stat     = r_ctl.stat;
    assign o_w_icode    = r_ctl.icode;
    assign o_w_dste     = r_ctl.dste;
    assign o_w_dstm     = r_ctl.dstm;
    assign o_w_vale     = r_vale;
    assign o_w_valm     = w_rdata;
    assign o_busy       = r_busy;
    assign o_dmem_error = r_err;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Randomised bench for mem_stage_pipe against a behavioural memory-stage model.
module tb_mem_stage_pipe;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 16;
    localparam logic [63:0] INITV = 64'd2;

    logic        clk;
    logic        rst_n;
    logic        s_stall, s_bubble;
    logic [3:0]  s_stat, s_icode, s_dste, s_dstm;
    logic [63:0] s_vala, s_vale, s_valp;
    logic [3:0]  d_stat, d_icode, d_dste, d_dstm;
    logic [63:0] d_vale, d_valm;
    logic        d_busy, d_err;

    int checks   = 0;
    int failures = 0;

    mem_stage_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .INIT_VAL(INITV)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_m_stall    (s_stall),
        .i_m_bubble   (s_bubble),
        .i_m_stat     (s_stat),
        .i_m_icode    (s_icode),
        .i_m_vala     (s_vala),
        .i_m_vale     (s_vale),
        .i_m_valp     (s_valp),
        .i_m_dste     (s_dste),
        .i_m_dstm     (s_dstm),
        .o_w_stat     (d_stat),
        .o_w_icode    (d_icode),
        .o_w_vale     (d_vale),
        .o_w_valm     (d_valm),
        .o_w_dste     (d_dste),
        .o_w_dstm     (d_dstm),
        .o_busy       (d_busy),
        .o_dmem_error (d_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] mm [DEPTH];
    int          boot_left;
    bit          halted;
    logic [3:0]  e_stat, e_icode, e_dste, e_dstm;
    logic [63:0] e_vale, e_valm;
    logic        e_busy, e_err;

    // What the M instruction asks of memory: 0 none, 1 read, 2 write.
    int          p_kind;
    logic [63:0] p_addr, p_data;
    bit          p_bad;
    int          p_idx;
    logic [3:0]  p_stat;

    always @* begin
        p_kind = 0;
        p_addr = s_vale;
        p_data = s_vala;
        case (s_icode)
            4'h4, 4'hA: p_kind = 2;
            4'h8: begin p_kind = 2; p_data = s_valp; end
            4'h5: p_kind = 1;
            4'h9, 4'hB: begin p_kind = 1; p_addr = s_vala; end
            default: p_kind = 0;
        endcase
        if (s_stat != 4'h1) p_kind = 0;
        p_bad  = (p_addr % 8 != 0) || (p_addr / 8 >= 64'(DEPTH));
        p_idx  = int'(p_addr[31:0] / 8);
        p_stat = (p_kind != 0 && p_bad) ? 4'h3 : s_stat;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_left <= DEPTH;
            halted    <= 1'b0;
            e_busy    <= 1'b1;
            e_stat    <= 4'h1;
            e_icode   <= 4'h1;
            e_dste    <= 4'hF;
            e_dstm    <= 4'hF;
            e_vale    <= '0;
            e_valm    <= '0;
            e_err     <= 1'b0;
        end else if (boot_left > 0) begin
            mm[DEPTH - boot_left] <= INITV;
            boot_left <= boot_left - 1;
            e_busy    <= (boot_left > 1);
        end else if (!halted && !s_stall) begin
            if (s_bubble) begin
                e_stat  <= 4'h1;
                e_icode <= 4'h1;
                e_dste  <= 4'hF;
                e_dstm  <= 4'hF;
                e_vale  <= '0;
                e_valm  <= '0;
                e_err   <= 1'b0;
            end else begin
                e_stat  <= p_stat;
                e_icode <= s_icode;
                e_dste  <= s_dste;
                e_dstm  <= s_dstm;
                e_vale  <= s_vale;
                e_err   <= (p_kind != 0) && p_bad;
                e_valm  <= (p_kind == 1 && !p_bad) ? mm[p_idx] : 64'd0;
                if (p_kind == 2 && !p_bad) mm[p_idx] <= p_data;
                halted  <= (p_stat != 4'h1);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("w_stat", 64'(d_stat), 64'(e_stat));
        chk("w_icode", 64'(d_icode), 64'(e_icode));
        chk("w_dstE", 64'(d_dste), 64'(e_dste));
        chk("w_dstM", 64'(d_dstm), 64'(e_dstm));
        chk("w_valE", d_vale, e_vale);
        chk("w_valM", d_valm, e_valm);
        chk("busy", 64'(d_busy), 64'(e_busy));
        chk("dmem_error", 64'(d_err), 64'(e_err));
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [3:0] stat, input logic [3:0] icode,
                         input logic [63:0] vala, input logic [63:0] vale,
                         input logic [63:0] valp, input logic stall, input logic bubble);
        s_stat   = stat;
        s_icode  = icode;
        s_vala   = vala;
        s_vale   = vale;
        s_valp   = valp;
        s_stall  = stall;
        s_bubble = bubble;
        s_dste   = 4'($urandom_range(0, 15));
        s_dstm   = 4'($urandom_range(0, 15));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sweep();
        int n = 0;
        bit done = 0;
        for (int i = 0; i < 4 * DEPTH && !done; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!d_busy) done = 1;
        end
        chk("sweep_done", 64'(done), 64'd1);
        chk("busy_cycles", 64'(n), 64'(DEPTH));
    endtask

    task automatic do_reset();
        s_stall  = 1'b0;
        s_bubble = 1'b0;
        s_stat   = 4'h1;
        s_icode  = 4'h1;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] a, d;
        logic [3:0]  ic, st;
        int          r;
        s_vala = '0; s_vale = '0; s_valp = '0; s_dste = 4'hF; s_dstm = 4'hF;
        do_reset();
        chk("reset_busy", 64'(d_busy), 64'd1);
        chk("reset_stat", 64'(d_stat), 64'd1);
        chk("reset_dstE", 64'(d_dste), 64'hF);
        wait_sweep();

        issue(4'h1, 4'h5, 64'd0, 64'h40, 64'd0, 1'b0, 1'b0);
        chk("mrmovq_init_val", d_valm, 64'd2);

        issue(4'h1, 4'hA, 64'h1234, 64'h78, 64'd0, 1'b0, 1'b0);
        issue(4'h1, 4'hB, 64'h78, 64'h80, 64'd0, 1'b0, 1'b0);
        chk("pop_after_push", d_valm, 64'h1234);

        issue(4'h1, 4'h8, 64'd0, 64'h10, 64'h99, 1'b1, 1'b1);
        issue(4'h1, 4'h8, 64'd0, 64'h10, 64'h99, 1'b1, 1'b1);
        chk("stall_hold_icode", 64'(d_icode), 64'hB);
        chk("stall_hold_valM", d_valm, 64'h1234);
        issue(4'h1, 4'h8, 64'd0, 64'h10, 64'h99, 1'b0, 1'b1);
        chk("bubble_icode", 64'(d_icode), 64'h1);
        chk("bubble_dstE", 64'(d_dste), 64'hF);
        issue(4'h1, 4'h5, 64'd0, 64'h10, 64'd0, 1'b0, 1'b0);
        chk("no_write_on_stall", d_valm, 64'd2);

        // Misaligned write halts; a later write must not land.
        issue(4'h1, 4'h4, 64'h55, 64'h81, 64'd0, 1'b0, 1'b0);
        chk("misalign_stat", 64'(d_stat), 64'h3);
        chk("misalign_err", 64'(d_err), 64'h1);
        issue(4'h1, 4'h4, 64'h55, 64'h70, 64'd0, 1'b0, 1'b0);
        issue(4'h1, 4'h4, 64'h55, 64'h70, 64'd0, 1'b0, 1'b0);
        chk("halt_frozen_valE", d_vale, 64'h81);
        chk("halt_no_write", u_dut.u_ram.r_mem[14], 64'd2);
        chk("halt_no_write_model", u_dut.u_ram.r_mem[14], mm[14]);

        do_reset();
        wait_sweep();
        issue(4'h1, 4'h5, 64'd0, 64'(DEPTH * 8), 64'd0, 1'b0, 1'b0);
        chk("oob_stat", 64'(d_stat), 64'h3);
        chk("oob_valM", d_valm, 64'd0);

        // Reset pulse in the middle of the sweep restarts it.
        do_reset();
        repeat (5) begin @(posedge clk); #1; end
        do_reset();
        wait_sweep();

        for (int round = 0; round < 6; round++) begin
            do_reset();
            wait_sweep();
            for (int k = 0; k < 60; k++) begin
                ic = 4'($urandom_range(0, 11));
                r  = int'($urandom_range(0, 99));
                if (r < 4)      a = 64'($urandom_range(0, DEPTH - 1) * 8 + $urandom_range(1, 7));
                else if (r < 7) a = 64'((DEPTH + $urandom_range(0, 40)) * 8);
                else            a = 64'($urandom_range(0, DEPTH - 1) * 8);
                d  = rnd64();
                st = ($urandom_range(0, 99) < 3) ? 4'($urandom_range(2, 4)) : 4'h1;
                if (ic == 4'h9 || ic == 4'hB)
                    issue(st, ic, a, d, rnd64(), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
                else
                    issue(st, ic, d, a, rnd64(), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
